// File: rtl/dmem_interface_if.sv
// Memory-side bus of the data memory interface: one outstanding word access,
// held stable by the master until the slave acknowledges.
interface dmem_interface_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dmem_interface.sv
// Load/store unit between the core pipeline and a word-wide data memory:
// alignment checking, byte-lane steering, load extension and ack timeout.
module dmem_interface (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        load_control,
    input  logic [1:0]        store_control,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_error,
    dmem_interface_if.master  mem
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_B    = 3'b001;
    localparam logic [2:0] LD_H    = 3'b010;
    localparam logic [2:0] LD_W    = 3'b011;
    localparam logic [2:0] LD_BU   = 3'b100;
    localparam logic [2:0] LD_HU   = 3'b101;
    localparam logic [1:0] ST_B    = 2'b01;
    localparam logic [1:0] ST_H    = 2'b10;
    localparam logic [1:0] ST_W    = 2'b11;
    localparam logic [3:0] WAIT_LAST = 4'd14;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [2:0]  ld_op_q, ld_op_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q, bus_error_d;

    logic        load_valid;
    logic        store_valid;
    logic        req_valid;
    logic        misalign_now;
    logic [3:0]  be_now;
    logic [31:0] wdata_now;

    // Shift the addressed lane down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                                input logic [1:0]  lo,
                                                input logic [31:0] word);
        logic [31:0] lane;
        lane = word >> {lo, 3'b000};
        case (op)
            LD_B:    load_extend = {{24{lane[7]}}, lane[7:0]};
            LD_H:    load_extend = {{16{lane[15]}}, lane[15:0]};
            LD_BU:   load_extend = {24'd0, lane[7:0]};
            LD_HU:   load_extend = {16'd0, lane[15:0]};
            default: load_extend = word;
        endcase
    endfunction

    // Codes 110/111 are not loads, so a store alongside them still executes.
    always_comb begin
        load_valid   = (load_control >= LD_B) && (load_control <= LD_HU);
        store_valid  = (store_control != 2'b00);
        req_valid    = load_valid || store_valid;
        misalign_now = 1'b0;
        be_now       = 4'b1111;
        wdata_now    = mem_wdata_q;
        if (load_valid) begin
            case (load_control)
                LD_H, LD_HU: misalign_now = addr[0];
                LD_W:        misalign_now = (addr[1:0] != 2'b00);
                default:     misalign_now = 1'b0;
            endcase
        end else if (store_valid) begin
            case (store_control)
                ST_B: begin
                    be_now    = 4'b0001 << addr[1:0];
                    wdata_now = {4{wdata[7:0]}};
                end
                ST_H: begin
                    misalign_now = addr[0];
                    be_now       = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_now    = {2{wdata[15:0]}};
                end
                default: begin
                    misalign_now = (addr[1:0] != 2'b00);
                    be_now       = 4'b1111;
                    wdata_now    = wdata;
                end
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        ld_op_d      = ld_op_q;
        addr_lo_d    = addr_lo_q;
        rdata_d      = rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        misaligned_d = 1'b0;
        bus_error_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    ld_op_d   = load_valid ? load_control : LD_NONE;
                    addr_lo_d = addr[1:0];
                    if (misalign_now) begin
                        misaligned_d = 1'b1;
                        state_d      = S_ERR;
                    end else begin
                        state_d     = S_REQ;
                        wait_d      = 4'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = !load_valid;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = be_now;
                        mem_wdata_d = wdata_now;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_DONE;
                    if (ld_op_q != LD_NONE) begin
                        rdata_d = load_extend(ld_op_q, addr_lo_q, mem.mem_rdata);
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Fifteenth unacknowledged cycle: give up on the access.
                    wait_d      = wait_q + 4'd1;
                    mem_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = S_ERR;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wait_q       <= 4'd0;
            ld_op_q      <= LD_NONE;
            rdata_q      <= 32'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            ld_op_q      <= ld_op_d;
            rdata_q      <= rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_lo_q <= addr_lo_d;
    end

    assign stall         = req_valid && ((state_q == S_IDLE) || (state_q == S_REQ));
    assign rdata         = rdata_q;
    assign misaligned    = misaligned_q;
    assign bus_error     = bus_error_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_interface.sv
// Directed bench for dmem_interface: a vector table of single accesses plus
// hand-written reset, idle-ack and mid-transaction reset sequences.
module tb_dmem_interface;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  load_control;
    logic [1:0]  store_control;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        bus_error;

    dmem_interface_if bus ();

    dmem_interface dut (
        .clock         (clock),
        .reset         (reset),
        .load_control  (load_control),
        .store_control (store_control),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .stall         (stall),
        .misaligned    (misaligned),
        .bus_error     (bus_error),
        .mem           (bus.master)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;      // value the memory returns
        int          delay;   // REQ cycles before ack; 15 means never
        bit          mis;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        bit          e_we;
        logic [31:0] e_wd;
        logic [31:0] e_rdata; // rdata after the access completes
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t vecs[13];
    vec_t post_rst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drop_req();
        load_control  = 3'd0;
        store_control = 2'd0;
        addr          = 32'd0;
        wdata         = 32'd0;
    endtask

    // Entered just after a falling edge with the DUT idle.
    task automatic run_vec(input vec_t v, input int idx);
        bit done;
        load_control  = v.ld;
        store_control = v.st;
        addr          = v.a;
        wdata         = v.wd;
        #1;
        chk($sformatf("v%0d stall_accept", idx), {31'd0, stall}, 32'd1);
        @(negedge clock);
        if (v.mis) begin
            chk($sformatf("v%0d misaligned", idx), {31'd0, misaligned}, 32'd1);
            chk($sformatf("v%0d no_req", idx), {31'd0, bus.mem_req}, 32'd0);
            chk($sformatf("v%0d stall_err", idx), {31'd0, stall}, 32'd0);
            drop_req();
            @(negedge clock);
            chk($sformatf("v%0d mis_pulse_end", idx), {31'd0, misaligned}, 32'd0);
            chk($sformatf("v%0d no_req2", idx), {31'd0, bus.mem_req}, 32'd0);
            chk($sformatf("v%0d rdata", idx), rdata, v.e_rdata);
        end else begin
            done = 1'b0;
            for (int k = 0; k < 15 && !done; k++) begin
                chk($sformatf("v%0d mem_req c%0d", idx, k), {31'd0, bus.mem_req}, 32'd1);
                chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.e_addr);
                chk($sformatf("v%0d mem_be", idx), {28'd0, bus.mem_be}, {28'd0, v.e_be});
                chk($sformatf("v%0d mem_we", idx), {31'd0, bus.mem_we}, {31'd0, v.e_we});
                if (v.e_we)
                    chk($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.e_wd);
                chk($sformatf("v%0d stall_req", idx), {31'd0, stall}, 32'd1);
                bus.mem_rdata = v.rd;
                bus.mem_ack   = (k == v.delay);
                @(negedge clock);
                done = bus.mem_ack;
            end
            bus.mem_ack = 1'b0;
            chk($sformatf("v%0d mem_req_drop", idx), {31'd0, bus.mem_req}, 32'd0);
            chk($sformatf("v%0d stall_end", idx), {31'd0, stall}, 32'd0);
            chk($sformatf("v%0d bus_error", idx), {31'd0, bus_error}, {31'd0, (v.delay >= 15)});
            chk($sformatf("v%0d rdata_done", idx), rdata, v.e_rdata);
            drop_req();
            @(negedge clock);
            chk($sformatf("v%0d bus_error_end", idx), {31'd0, bus_error}, 32'd0);
            chk($sformatf("v%0d idle_req", idx), {31'd0, bus.mem_req}, 32'd0);
            chk($sformatf("v%0d rdata_idle", idx), rdata, v.e_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          ld    st    addr          wdata         mem_rdata     dly mis e_addr        e_be     we  e_wdata       e_rdata
        vecs[0]  = '{3'd1, 2'd0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0100, 4'b1111, 0, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{3'd0, 2'd2, 32'h0000_0202, 32'h0000_ABCD, 32'hFFFF_FFFF, 2, 0, 32'h0000_0200, 4'b1100, 1, 32'hABCD_ABCD, 32'hFFFF_FF80};
        vecs[2]  = '{3'd3, 2'd0, 32'h0000_0101, 32'h0,        32'h0,         0, 1, 32'h0,        4'b0000, 0, 32'h0,        32'hFFFF_FF80};
        vecs[3]  = '{3'd5, 2'd0, 32'h0000_0000, 32'h0,        32'h1111_2222, 15, 0, 32'h0000_0000, 4'b1111, 0, 32'h0,       32'hFFFF_FF80};
        vecs[4]  = '{3'd3, 2'd3, 32'h0000_0040, 32'hCAFE_0000, 32'h1234_5678, 1, 0, 32'h0000_0040, 4'b1111, 0, 32'h0,        32'h1234_5678};
        vecs[5]  = '{3'd2, 2'd0, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 0, 0, 32'h0000_0100, 4'b1111, 0, 32'h0,        32'hFFFF_8001};
        vecs[6]  = '{3'd4, 2'd0, 32'h0000_0101, 32'h0,        32'h0000_9A00, 3, 0, 32'h0000_0100, 4'b1111, 0, 32'h0,        32'h0000_009A};
        vecs[7]  = '{3'd0, 2'd1, 32'h0000_0007, 32'h1234_56EF, 32'hFFFF_FFFF, 0, 0, 32'h0000_0004, 4'b1000, 1, 32'hEFEF_EFEF, 32'h0000_009A};
        vecs[8]  = '{3'd0, 2'd3, 32'h0000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1, 0, 32'h0000_0010, 4'b1111, 1, 32'hDEAD_BEEF, 32'h0000_009A};
        vecs[9]  = '{3'd0, 2'd2, 32'h0000_0003, 32'h0000_1234, 32'h0,         0, 1, 32'h0,        4'b0000, 0, 32'h0,        32'h0000_009A};
        vecs[10] = '{3'd2, 2'd0, 32'h0000_0100, 32'h0,        32'h1234_F00D, 0, 0, 32'h0000_0100, 4'b1111, 0, 32'h0,        32'hFFFF_F00D};
        vecs[11] = '{3'd0, 2'd1, 32'h0000_0001, 32'h0000_00AB, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 4'b0010, 1, 32'hABAB_ABAB, 32'hFFFF_F00D};
        vecs[12] = '{3'd6, 2'd1, 32'h0000_0002, 32'h0000_0055, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 4'b0100, 1, 32'h5555_5555, 32'hFFFF_F00D};
        post_rst = '{3'd3, 2'd0, 32'h0000_0008, 32'h0,        32'h0BAD_F00D, 0, 0, 32'h0000_0008, 4'b1111, 0, 32'h0,        32'h0BAD_F00D};

        reset         = 1'b1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        drop_req();
        #1;
        chk("rst rdata", rdata, 32'd0);
        chk("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst mem_be", {28'd0, bus.mem_be}, 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst bus_error", {31'd0, bus_error}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("idle stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Ack outside REQ must not start or complete anything.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        @(negedge clock);
        chk("idle_ack mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("idle_ack rdata", rdata, 32'hFFFF_F00D);
        bus.mem_ack = 1'b0;

        // Reset in the middle of an outstanding load.
        load_control = 3'd3;
        addr         = 32'h0000_0020;
        @(negedge clock);
        chk("midrst mem_req_before", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hAAAA_AAAA;
        #2 reset = 1'b1;
        #1;
        chk("midrst mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("midrst mem_addr", bus.mem_addr, 32'd0);
        chk("midrst mem_be", {28'd0, bus.mem_be}, 32'd0);
        chk("midrst rdata", rdata, 32'd0);
        @(negedge clock);
        chk("midrst rdata_after_edge", rdata, 32'd0);
        bus.mem_ack = 1'b0;
        drop_req();
        reset = 1'b0;
        run_vec(post_rst, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_interface.md
DMEM_INTERFACE -- requirements
Module: dmem_interface

Interface
REQ-001 SHALL have port clock, input, 1, single system clock, all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port load_control, input, 3, load request from decoder: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110/111 treated as none.
REQ-004 SHALL have port store_control, input, 2, store request from decoder: 00 none, 01 SB, 10 SH, 11 SW.
REQ-005 SHALL have port addr, input, 32, byte address from ALU result.
REQ-006 SHALL have port wdata, input, 32, store data (rs2).
REQ-007 SHALL have port rdata, output, 32, extended load result for register file, registered.
REQ-008 SHALL have port stall, output, 1, core hold request, combinational.
REQ-009 SHALL have port misaligned, output, 1, one-cycle pulse on alignment fault.
REQ-010 SHALL have port bus_error, output, 1, one-cycle pulse on memory timeout.
REQ-011 SHALL have ports mem_req (out,1), mem_we (out,1), mem_addr (out,32), mem_be (out,4), mem_wdata (out,32), all registered; mem_rdata (in,32); mem_ack (in,1).

Function
REQ-012 SHALL implement FSM states IDLE, REQ, DONE, ERR.
REQ-013 IDLE: nonzero load_control or store_control SHALL latch op, addr, wdata; aligned -> REQ next cycle; misaligned -> ERR next cycle.
REQ-014 Misaligned SHALL mean: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00; byte ops never misaligned.
REQ-015 Both load and store nonzero in same cycle SHALL execute the load only; store ignored.
REQ-016 REQ: mem_req=1, mem_addr={addr[31:2],2'b00}, mem_we=1 for stores, 0 for loads; all held stable until mem_ack sampled high.
REQ-017 Store byte enables SHALL be: SB 0001<<addr[1:0]; SH 0011 (addr[1]=0) or 1100 (addr[1]=1); SW 1111; loads SHALL drive mem_be=1111.
REQ-018 mem_wdata SHALL replicate: SB byte into all 4 lanes, SH halfword into both halves, SW unmodified.
REQ-019 On mem_ack in REQ with a load SHALL select lane by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), register into rdata, go DONE; store -> DONE, rdata unchanged.
REQ-020 mem_req SHALL deassert in the cycle after mem_ack is sampled.
REQ-021 A 4-bit wait counter SHALL clear on entering REQ and increment each REQ cycle without ack; on reaching 15 without ack SHALL drop mem_req, pulse bus_error, go ERR.
REQ-022 ERR: misaligned or bus_error high for exactly that cycle; no memory access; rdata unchanged; -> IDLE next cycle.
REQ-023 DONE: one cycle, -> IDLE unconditionally; a new request is accepted only from IDLE.
REQ-024 stall SHALL equal (request nonzero) AND state in {IDLE, REQ}; stall SHALL be 0 in DONE and ERR.
REQ-025 Minimum latency SHALL be 3 cycles: IDLE accept (c0), REQ with ack (c1), DONE (c2); stall high c0-c1, low c2.
REQ-026 mem_ack outside REQ SHALL be ignored.

Reset
REQ-027 reset SHALL asynchronously force state IDLE, wait counter 0, rdata 0, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, misaligned 0, bus_error 0.
REQ-028 reset mid-transaction SHALL abandon the access immediately; no partial rdata update; first post-reset request starts from IDLE.

Verification
REQ-029 LB addr=0x103, mem_rdata=0x80FF_1234, ack on first REQ cycle -> mem_addr=0x100, mem_be=1111, rdata=0xFFFF_FF80, stall low in 3rd cycle.
REQ-030 SH addr=0x202, wdata=0x0000_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, rdata unchanged.
REQ-031 LW addr=0x101 -> no mem_req, misaligned pulses 1 cycle, stall low in ERR cycle.
REQ-032 LHU addr=0x000, ack withheld 15 REQ cycles -> mem_req drops, bus_error pulses 1 cycle, FSM returns IDLE.
REQ-033 load_control=LW and store_control=SW simultaneously, addr=0x40 -> mem_we=0, only one access issued.
REQ-034 reset asserted during REQ with mem_req=1 -> mem_req=0 and all outputs at reset values without waiting for clock edge.
